piano_poly_ctrl: RTL and testbench
==================================

PIANO_POLY_CTRL -- requirements
Module: piano_poly_ctrl

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of simultaneous note voices (1..8).
REQ-002 SHALL have parameter NOTE_W, default 8, width of a note code.
REQ-003 SHALL have parameter DURATION, default 50_000_000, note length in clk cycles (0.5 s at 100 MHz).
REQ-004 SHALL have parameter TIMER_W, default 27, width of each voice timer (2**TIMER_W > DURATION).
REQ-005 SHALL have parameters OCT_MIN, default -3, and OCT_MAX, default 3, which are the octave saturation limits.
REQ-006 SHALL have port clk  input  1  system clock (100 MHz); the block uses this one clock only.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port note_valid  input  1  one-cycle strobe qualifying note_data.
REQ-009 SHALL have port note_data  input  NOTE_W  note code; codes 2..11 are legal.
REQ-010 SHALL have ports oct_up and oct_down  input  1 each  debounced button levels.
REQ-011 SHALL have port voice_active  output  NUM_VOICES  per-voice sounding flag.
REQ-012 SHALL have port voice_note  output  NUM_VOICES*NOTE_W  per-voice note code, where voice i occupies bits [i*NOTE_W +: NOTE_W].
REQ-013 SHALL have port octave_shift  output  4  signed current octave offset.
REQ-014 SHALL have port invalid_pulse  output  1  one-cycle flag marking a rejected note.
REQ-015 SHALL have ports seg  output  7  active-low segments, and an  output  4  active-low digit enables.

Function
REQ-016 SHALL register every output, with no combinational path from any input to any output.
REQ-017 SHALL accept a note (note_valid=1, note_data in 2..11) at edge N and drive the selected voice's voice_active=1 and voice_note at edge N+1.
REQ-018 SHALL, when an active voice already holds the same code, retrigger it: timer cleared to 0, no new voice allocated.
REQ-019 SHALL otherwise allocate the lowest-index idle voice.
REQ-020 SHALL, when all voices are active, steal the voice with the largest timer value (lowest index on ties), then load the new code and clear its timer.
REQ-021 SHALL ignore note_valid with a code outside 2..11, leave voice state unchanged, and assert invalid_pulse for exactly one cycle at N+1.
REQ-022 SHALL count each active voice's timer up by 1 per cycle and clear voice_active on the edge where the timer equals DURATION-1, giving exactly DURATION active cycles.
REQ-023 SHALL, when a timer expiry and a new note for the same voice coincide, let the new note win.
REQ-024 SHALL keep voice_note at its last value after the voice goes idle.
REQ-025 SHALL increment octave_shift on an oct_up rising edge and decrement it on an oct_down rising edge, detected against a registered previous level.
REQ-026 SHALL saturate octave_shift at OCT_MAX and OCT_MIN with no wrap.
REQ-027 SHALL leave octave_shift unchanged when both rising edges occur in the same cycle.
REQ-028 SHALL update seg one cycle after each accepted note, per the package table: code 2..10 shows digits 1..9 and code 11 shows digit 0; rejected notes leave seg unchanged.
REQ-029 SHALL hold an at 4'b1110.

Reset
REQ-030 SHALL, on reset assertion, asynchronously clear voice_active, voice_note, all timers, octave_shift, invalid_pulse and the previous-button registers to 0, set seg to 7'b1111111 (blank) and set an to 4'b1110.
REQ-031 SHALL abort any note in flight on reset, including mid-duration, and SHALL ignore a note_valid present during reset.
REQ-032 SHALL accept a note on the first clk edge after reset deasserts.

Structure
REQ-033 SHALL take NOTE_MIN=2, NOTE_MAX=11, SEG_BLANK, the note-to-segment function and the octave limit defaults from shared package piano_pkg.
REQ-034 SHALL instantiate NUM_VOICES copies of sub-module piano_voice (load/retrigger input, timer, active flag, note register), keeping allocation and stealing logic in piano_poly_ctrl.

Verification (DURATION=16, NUM_VOICES=4)
REQ-035 SHALL check: note 5 at cycle 0 -> voice_active=0001 at cycle 1, voice 0 note=5, active exactly 16 cycles, seg=7'b1001100.
REQ-036 SHALL check: notes 2,3,4,5,6 on consecutive cycles -> voices 0..3 take 2..5, and note 6 steals voice 0.
REQ-037 SHALL check: note 7, then note 7 again 10 cycles later -> same voice retriggered and active for 26 cycles total, no other voice used.
REQ-038 SHALL check: note codes 0, 1, 12 -> invalid_pulse asserted 3 times, voice_active=0, seg blank.
REQ-039 SHALL check: five oct_up presses -> octave_shift reaches 3 and holds; seven oct_down presses -> reaches -3; simultaneous up and down edges -> no change.
REQ-040 SHALL check: reset asserted at cycle 8 of an active note -> all outputs at reset values immediately (asynchronously), and a note at the first edge after release plays normally.

Source files
------------

// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piano_pkg
//  Description : Shared note range, display constants and note-to-segment map.
//  Revision    : 1.0 - initial release
// ============================================================================
package piano_pkg;

    localparam int NOTE_MIN = 2;
    localparam int NOTE_MAX = 11;

    localparam int OCT_MIN_DEFAULT = -3;
    localparam int OCT_MAX_DEFAULT = 3;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_DEFAULT = 4'b1110;

    // Active-low segments, bit order {a,b,c,d,e,f,g}; code 2..10 -> 1..9, 11 -> 0
    function automatic logic [6:0] note_to_seg(input int code);
        logic [6:0] s;
        case (code)
            2:       s = 7'b1001111;
            3:       s = 7'b0010010;
            4:       s = 7'b0000110;
            5:       s = 7'b1001100;
            6:       s = 7'b0100100;
            7:       s = 7'b0100000;
            8:       s = 7'b0001111;
            9:       s = 7'b0000000;
            10:      s = 7'b0000100;
            11:      s = 7'b0000001;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piano_voice.sv
`default_nettype none
// ============================================================================
//  Module      : piano_voice
//  Description : One note voice: note register, duration timer, active flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module piano_voice #(
    parameter int NOTE_W   = 8,
    parameter int DURATION = 50_000_000,
    parameter int TIMER_W  = 27
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [NOTE_W-1:0]  load_note,
    output logic               active,
    output logic [NOTE_W-1:0]  note,
    output logic [TIMER_W-1:0] timer
);

    logic               active_q, active_d;
    logic [NOTE_W-1:0]  note_q,   note_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;

    // A load takes priority over expiry so a coincident new note keeps sounding
    always_comb begin
        active_d = active_q;
        note_d   = note_q;
        timer_d  = timer_q;
        if (load) begin
            active_d = 1'b1;
            note_d   = load_note;
            timer_d  = '0;
        end else if (active_q) begin
            if (timer_q == TIMER_W'(DURATION - 1)) begin
                active_d = 1'b0;
                timer_d  = '0;
            end else begin
                timer_d = timer_q + TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            note_q   <= '0;
            timer_q  <= '0;
        end else begin
            active_q <= active_d;
            note_q   <= note_d;
            timer_q  <= timer_d;
        end
    end

    assign active = active_q;
    assign note   = note_q;
    assign timer  = timer_q;

endmodule
`default_nettype wire

// File: rtl/piano_poly_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : piano_poly_ctrl
//  Description : Polyphonic note controller with voice stealing, octave shift
//                and 7-segment note display.
//  Revision    : 1.0 - initial release
// ============================================================================
module piano_poly_ctrl
    import piano_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 8,
    parameter int DURATION   = 50_000_000,
    parameter int TIMER_W    = 27,
    parameter int OCT_MIN    = OCT_MIN_DEFAULT,
    parameter int OCT_MAX    = OCT_MAX_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         note_valid,
    input  logic [NOTE_W-1:0]            note_data,
    input  logic                         oct_up,
    input  logic                         oct_down,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic signed [3:0]            octave_shift,
    output logic                         invalid_pulse,
    output logic [6:0]                   seg,
    output logic [3:0]                   an
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [TIMER_W-1:0]    voice_timer [NUM_VOICES];
    logic [NUM_VOICES-1:0] voice_load;

    logic                  note_ok;
    logic                  hit, idle_found;
    logic [IDX_W-1:0]      hit_idx, idle_idx, steal_idx, sel_idx;
    logic [TIMER_W-1:0]    best_timer;

    logic                  up_rise, down_rise;
    logic                  up_prev_q, up_prev_d;
    logic                  down_prev_q, down_prev_d;
    logic signed [3:0]     octave_q, octave_d;
    logic                  invalid_q, invalid_d;
    logic [6:0]            seg_q, seg_d;
    logic [3:0]            an_q;

    assign note_ok = (note_data >= NOTE_W'(NOTE_MIN)) && (note_data <= NOTE_W'(NOTE_MAX));

    // Priority: retrigger a matching voice, else lowest idle, else the oldest voice
    always_comb begin
        hit        = 1'b0;
        idle_found = 1'b0;
        hit_idx    = '0;
        idle_idx   = '0;
        steal_idx  = '0;
        best_timer = voice_timer[0];
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_active[i] && (voice_note[i*NOTE_W +: NOTE_W] == note_data)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!voice_active[i]) begin
                idle_found = 1'b1;
                idle_idx   = IDX_W'(i);
            end
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (voice_timer[i] > best_timer) begin
                best_timer = voice_timer[i];
                steal_idx  = IDX_W'(i);
            end
        end
        if (hit)
            sel_idx = hit_idx;
        else if (idle_found)
            sel_idx = idle_idx;
        else
            sel_idx = steal_idx;
        voice_load = '0;
        if (note_valid && note_ok)
            voice_load[sel_idx] = 1'b1;
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
            piano_voice #(
                .NOTE_W   (NOTE_W),
                .DURATION (DURATION),
                .TIMER_W  (TIMER_W)
            ) u_voice (
                .clk       (clk),
                .reset     (reset),
                .load      (voice_load[g]),
                .load_note (note_data),
                .active    (voice_active[g]),
                .note      (voice_note[g*NOTE_W +: NOTE_W]),
                .timer     (voice_timer[g])
            );
        end
    endgenerate

    // Simultaneous up/down edges cancel out
    always_comb begin
        up_rise     = oct_up & ~up_prev_q;
        down_rise   = oct_down & ~down_prev_q;
        up_prev_d   = oct_up;
        down_prev_d = oct_down;
        octave_d    = octave_q;
        if (up_rise && !down_rise && (int'(octave_q) < OCT_MAX))
            octave_d = octave_q + 4'sd1;
        else if (down_rise && !up_rise && (int'(octave_q) > OCT_MIN))
            octave_d = octave_q - 4'sd1;
        invalid_d = note_valid & ~note_ok;
        seg_d     = seg_q;
        if (note_valid && note_ok)
            seg_d = note_to_seg(int'(note_data));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            octave_q    <= '0;
            invalid_q   <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= AN_DEFAULT;
        end else begin
            up_prev_q   <= up_prev_d;
            down_prev_q <= down_prev_d;
            octave_q    <= octave_d;
            invalid_q   <= invalid_d;
            seg_q       <= seg_d;
            an_q        <= AN_DEFAULT;
        end
    end

    assign octave_shift  = octave_q;
    assign invalid_pulse = invalid_q;
    assign seg           = seg_q;
    assign an            = an_q;

endmodule
`default_nettype wire

// File: tb/tb_piano_poly_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piano_poly_ctrl
//  Description : Directed and randomized bench for piano_poly_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piano_poly_ctrl;

    localparam int NV  = 4;
    localparam int NW  = 8;
    localparam int DUR = 16;
    localparam int TW  = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          note_valid = 1'b0;
    logic [NW-1:0] note_data = '0;
    logic          oct_up = 1'b0;
    logic          oct_down = 1'b0;
    logic [NV-1:0]    voice_active;
    logic [NV*NW-1:0] voice_note;
    logic [3:0]       octave_shift;
    logic             invalid_pulse;
    logic [6:0]       seg;
    logic [3:0]       an;

    piano_poly_ctrl #(
        .NUM_VOICES (NV),
        .NOTE_W     (NW),
        .DURATION   (DUR),
        .TIMER_W    (TW),
        .OCT_MIN    (-3),
        .OCT_MAX    (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .note_valid    (note_valid),
        .note_data     (note_data),
        .oct_up        (oct_up),
        .oct_down      (oct_down),
        .voice_active  (voice_active),
        .voice_note    (voice_note),
        .octave_shift  (octave_shift),
        .invalid_pulse (invalid_pulse),
        .seg           (seg),
        .an            (an)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a voice sounds for DUR cycles from the cycle it was loaded
    int          m_t = 0;
    bit          m_on    [NV];
    int          m_start [NV];
    logic [7:0]  m_note  [NV];
    int          m_oct;
    logic [6:0]  m_seg;
    bit          m_inv;
    bit          m_up_prev, m_dn_prev;
    logic [6:0]  digit_seg [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                    7'b0000000, 7'b0000100};

    function automatic bit m_act(input int i);
        return m_on[i] && ((m_t - m_start[i]) < DUR);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_on[i]    = 1'b0;
            m_start[i] = 0;
            m_note[i]  = '0;
        end
        m_oct     = 0;
        m_seg     = 7'b1111111;
        m_inv     = 1'b0;
        m_up_prev = 1'b0;
        m_dn_prev = 1'b0;
    endtask

    task automatic model_edge();
        int sel;
        int didx;
        bit ur, dr;
        sel   = -1;
        m_inv = 1'b0;
        if (note_valid) begin
            if (note_data >= 2 && note_data <= 11) begin
                for (int i = 0; i < NV; i++)
                    if (sel < 0 && m_act(i) && m_note[i] == note_data) sel = i;
                for (int i = 0; i < NV; i++)
                    if (sel < 0 && !m_act(i)) sel = i;
                if (sel < 0) begin
                    sel = 0;
                    for (int i = 1; i < NV; i++)
                        if (m_start[i] < m_start[sel]) sel = i;
                end
            end else begin
                m_inv = 1'b1;
            end
        end
        ur = oct_up && !m_up_prev;
        dr = oct_down && !m_dn_prev;
        if (ur && !dr)
            m_oct = (m_oct < 3) ? m_oct + 1 : 3;
        else if (dr && !ur)
            m_oct = (m_oct > -3) ? m_oct - 1 : -3;
        m_up_prev = oct_up;
        m_dn_prev = oct_down;
        m_t++;
        if (sel >= 0) begin
            m_on[sel]    = 1'b1;
            m_start[sel] = m_t;
            m_note[sel]  = note_data;
            didx         = (note_data == 11) ? 0 : int'(note_data) - 1;
            m_seg        = digit_seg[didx];
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [NV-1:0]    ea;
        logic [NV*NW-1:0] en;
        logic [3:0]       eo;
        for (int i = 0; i < NV; i++) begin
            ea[i]           = m_act(i);
            en[i*NW +: NW]  = m_note[i];
        end
        eo = 4'(m_oct);
        check({tag, ":voice_active"},  64'(voice_active),  64'(ea));
        check({tag, ":voice_note"},    64'(voice_note),    64'(en));
        check({tag, ":octave_shift"},  64'(octave_shift),  64'(eo));
        check({tag, ":invalid_pulse"}, 64'(invalid_pulse), 64'(m_inv));
        check({tag, ":seg"},           64'(seg),           64'(m_seg));
        check({tag, ":an"},            64'(an),            64'(4'b1110));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all("step");
    endtask

    task automatic cyc(input logic v, input logic [NW-1:0] d);
        note_valid = v;
        note_data  = d;
        step();
        note_valid = 1'b0;
    endtask

    task automatic press(input logic u, input logic d);
        oct_up   = u;
        oct_down = d;
        step();
        oct_up   = 1'b0;
        oct_down = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_inv;
        logic [NV-1:0] others;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        reset = 1'b0;

        // Rejected codes: pulse only, no voice, display stays blank
        n_inv = 0;
        cyc(1'b1, 8'd0);  n_inv += int'(invalid_pulse);
        cyc(1'b1, 8'd1);  n_inv += int'(invalid_pulse);
        cyc(1'b1, 8'd12); n_inv += int'(invalid_pulse);
        step();
        check("inv_count",  64'(n_inv), 64'(3));
        check("inv_idle",   64'(voice_active), 64'(4'b0000));
        check("inv_seg",    64'(seg), 64'(7'b1111111));
        check("inv_clear",  64'(invalid_pulse), 64'(0));

        // Single note 5
        cyc(1'b1, 8'd5);
        check("n5_active", 64'(voice_active), 64'(4'b0001));
        check("n5_note",   64'(voice_note[7:0]), 64'(8'd5));
        check("n5_seg",    64'(seg), 64'(7'b1001100));
        n = 1;
        repeat (40) begin
            step();
            if (voice_active[0]) n++;
        end
        check("n5_duration", 64'(n), 64'(16));

        // Five notes back to back: fifth steals voice 0
        for (int k = 2; k <= 6; k++) cyc(1'b1, 8'(k));
        check("steal_active", 64'(voice_active), 64'(4'b1111));
        check("steal_notes",  64'(voice_note), 64'(32'h05040306));
        repeat (20) step();

        // Retrigger of note 7 ten cycles after first strike
        others = '0;
        cyc(1'b1, 8'd7);
        n = int'(voice_active[0]);
        repeat (9) begin
            step();
            if (voice_active[0]) n++;
            others |= voice_active & 4'b1110;
        end
        cyc(1'b1, 8'd7);
        if (voice_active[0]) n++;
        others |= voice_active & 4'b1110;
        repeat (30) begin
            step();
            if (voice_active[0]) n++;
            others |= voice_active & 4'b1110;
        end
        check("retrig_duration", 64'(n), 64'(26));
        check("retrig_others",   64'(others), 64'(4'b0000));
        check("retrig_note",     64'(voice_note[7:0]), 64'(8'd7));

        // Octave saturation and cancellation
        repeat (5) press(1'b1, 1'b0);
        check("oct_max", 64'(octave_shift), 64'(4'b0011));
        repeat (7) press(1'b0, 1'b1);
        check("oct_min", 64'(octave_shift), 64'(4'b1101));
        press(1'b1, 1'b0);
        check("oct_up1", 64'(octave_shift), 64'(4'b1110));
        press(1'b1, 1'b1);
        check("oct_both", 64'(octave_shift), 64'(4'b1110));

        // Randomized traffic against the model
        repeat (300) begin
            note_valid = ($urandom_range(0, 2) == 0);
            note_data  = 8'($urandom_range(0, 13));
            oct_up     = ($urandom_range(0, 3) == 0);
            oct_down   = ($urandom_range(0, 3) == 0);
            step();
        end
        note_valid = 1'b0;
        oct_up     = 1'b0;
        oct_down   = 1'b0;
        repeat (20) step();

        // Asynchronous reset in the middle of a note
        cyc(1'b1, 8'd9);
        repeat (7) step();
        check("pre_reset_active", 64'(voice_active), 64'(4'b0001));
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("async_reset");
        check("async_active", 64'(voice_active), 64'(4'b0000));
        check("async_seg",    64'(seg), 64'(7'b1111111));
        note_valid = 1'b1;
        note_data  = 8'd4;
        @(posedge clk);
        #1;
        compare_all("in_reset");
        reset      = 1'b0;
        note_valid = 1'b0;
        cyc(1'b1, 8'd3);
        check("post_active", 64'(voice_active), 64'(4'b0001));
        check("post_note",   64'(voice_note[7:0]), 64'(8'd3));
        check("post_seg",    64'(seg), 64'(7'b0010010));
        n = 1;
        repeat (40) begin
            step();
            if (voice_active[0]) n++;
        end
        check("post_duration", 64'(n), 64'(16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
